ahb_slave_interface: RTL and testbench

- AHB-side front end of the AHB2APB bridge, directly upstream of the APB FSM controller.
- Qualifies AHB transfers into `valid`.
- Decodes the peripheral select `tempselx`.
- Provides the one- and two-cycle delayed address/data/write pipeline (`Haddr1/2`, `Hwdata1/2`, `Hwritereg`) that the controller consumes.
- Detects accesses to unmapped addresses and runs the two-cycle AHB ERROR response.
- Counts those error events.

---
 rtl/ahb_slave_interface.sv | 162 ++++++++++++++++
 tb/tb_ahb_slave_interface.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB2APB bridge: transfer qualification, peripheral
// decode, free-running address/data delay pipeline, unmapped-address ERROR
// response and a saturating error-event counter.
module ahb_slave_interface #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned REGION_BITS = 26
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        Hwrite,
   input  logic        Hreadyin,
   input  logic [1:0]  Htrans,
   input  logic [31:0] Haddr,
   input  logic [31:0] Hwdata,
   input  logic [31:0] Prdata,
   output logic        valid,
   output logic [2:0]  tempselx,
   output logic [31:0] Haddr1,
   output logic [31:0] Haddr2,
   output logic [31:0] Hwdata1,
   output logic [31:0] Hwdata2,
   output logic        Hwritereg,
   output logic [31:0] Hrdata,
   output logic [1:0]  Hresp,
   output logic        err_hready,
   output logic [7:0]  err_count
);

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned NUM_REGS  = 3;
   localparam logic [1:0]  RESP_OKAY = 2'b00;
   localparam logic [1:0]  RESP_ERR  = 2'b01;

   typedef enum logic [1:0] {
      ST_OK   = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } err_state_e;

   err_state_e         state_q, state_d;
   logic [1:0]         hresp_q, hresp_d;
   logic               err_hready_q, err_hready_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic [ADDR_W-1:0]  haddr1_q, haddr1_d;
   logic [ADDR_W-1:0]  haddr2_q, haddr2_d;
   logic [ADDR_W-1:0]  hwdata1_q, hwdata1_d;
   logic [ADDR_W-1:0]  hwdata2_q, hwdata2_d;
   logic               hwritereg_q, hwritereg_d;

   logic               active;
   logic               in_range;
   logic [ADDR_W-1:0]  off;
   logic [ADDR_W-1:0]  off_hi;
   logic [1:0]         idx;
   logic [2:0]         sel;
   logic               unused_htrans0;

   // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
   assign unused_htrans0 = Htrans[0];

   // Address window decode; the >= term keeps a wrapped offset from aliasing.
   always_comb begin
      active   = Hreadyin & Htrans[1];
      off      = Haddr - BASE_ADDR;
      off_hi   = off >> REGION_BITS;
      idx      = off[REGION_BITS +: 2];
      in_range = (Haddr >= BASE_ADDR) && (off_hi < ADDR_W'(NUM_REGS));
      sel      = 3'b000;
      if (in_range) begin
         case (idx)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
         endcase
      end
   end

   // Free-running delay pipeline consumed by the APB controller.
   always_comb begin
      haddr1_d    = Haddr;
      haddr2_d    = haddr1_q;
      hwdata1_d   = Hwdata;
      hwdata2_d   = hwdata1_q;
      hwritereg_d = Hwrite;
   end

   // Error FSM next state, counter and state-decoded response outputs.
   always_comb begin
      state_d      = state_q;
      err_count_d  = err_count_q;
      hresp_d      = RESP_OKAY;
      err_hready_d = 1'b1;
      case (state_q)
         ST_OK: begin
            if (active && !in_range) begin
               state_d = ST_ERR1;
               if (err_count_q != {CNT_W{1'b1}}) begin
                  err_count_d = err_count_q + CNT_W'(1);
               end
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = ST_OK;
         default: state_d = ST_OK;
      endcase
      case (state_d)
         ST_ERR1: begin
            hresp_d      = RESP_ERR;
            err_hready_d = 1'b0;
         end
         ST_ERR2: begin
            hresp_d      = RESP_ERR;
            err_hready_d = 1'b1;
         end
         default: begin
            hresp_d      = RESP_OKAY;
            err_hready_d = 1'b1;
         end
      endcase
   end

   // State and pipeline registers.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q      <= ST_OK;
         hresp_q      <= RESP_OKAY;
         err_hready_q <= 1'b1;
         err_count_q  <= '0;
         haddr1_q     <= '0;
         haddr2_q     <= '0;
         hwdata1_q    <= '0;
         hwdata2_q    <= '0;
         hwritereg_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hresp_q      <= hresp_d;
         err_hready_q <= err_hready_d;
         err_count_q  <= err_count_d;
         haddr1_q     <= haddr1_d;
         haddr2_q     <= haddr2_d;
         hwdata1_q    <= hwdata1_d;
         hwdata2_q    <= hwdata2_d;
         hwritereg_q  <= hwritereg_d;
      end
   end

   // Output mapping; valid is suppressed while an ERROR response is running.
   assign valid      = active & in_range & (state_q == ST_OK);
   assign tempselx   = sel;
   assign Hrdata     = Prdata;
   assign Haddr1     = haddr1_q;
   assign Haddr2     = haddr2_q;
   assign Hwdata1    = hwdata1_q;
   assign Hwdata2    = hwdata2_q;
   assign Hwritereg  = hwritereg_q;
   assign Hresp      = hresp_q;
   assign err_hready = err_hready_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Randomized self-checking bench for ahb_slave_interface against a
// transaction-level reference model.
module tb_ahb_slave_interface;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam longint      RSIZE = 64'd1 << 26;

   logic        Hclk;
   logic        Hresetn;
   logic        Hwrite;
   logic        Hreadyin;
   logic [1:0]  Htrans;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [31:0] Prdata;
   logic        valid;
   logic [2:0]  tempselx;
   logic [31:0] Haddr1;
   logic [31:0] Haddr2;
   logic [31:0] Hwdata1;
   logic [31:0] Hwdata2;
   logic        Hwritereg;
   logic [31:0] Hrdata;
   logic [1:0]  Hresp;
   logic        err_hready;
   logic [7:0]  err_count;

   ahb_slave_interface dut (
      .Hclk       (Hclk),
      .Hresetn    (Hresetn),
      .Hwrite     (Hwrite),
      .Hreadyin   (Hreadyin),
      .Htrans     (Htrans),
      .Haddr      (Haddr),
      .Hwdata     (Hwdata),
      .Prdata     (Prdata),
      .valid      (valid),
      .tempselx   (tempselx),
      .Haddr1     (Haddr1),
      .Haddr2     (Haddr2),
      .Hwdata1    (Hwdata1),
      .Hwdata2    (Hwdata2),
      .Hwritereg  (Hwritereg),
      .Hrdata     (Hrdata),
      .Hresp      (Hresp),
      .err_hready (err_hready),
      .err_count  (err_count)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: delayed copies, remaining ERROR cycles, event count.
   logic [31:0] m_a1, m_a2, m_d1, m_d2;
   logic        m_w;
   int          m_err_left;
   int          m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [2:0] model_sel(input logic [31:0] a);
      longint la = longint'(a);
      longint lb = longint'(BASE);
      if (la >= lb && la < lb + 3 * RSIZE) return 3'(1 << ((la - lb) / RSIZE));
      return 3'b000;
   endfunction

   task automatic model_reset();
      m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w = 1'b0;
      m_err_left = 0; m_cnt = 0;
   endtask

   task automatic check_regs();
      check("haddr1",     Haddr1, m_a1);
      check("haddr2",     Haddr2, m_a2);
      check("hwdata1",    Hwdata1, m_d1);
      check("hwdata2",    Hwdata2, m_d2);
      check("hwritereg",  32'(Hwritereg), 32'(m_w));
      check("hresp",      32'(Hresp), (m_err_left > 0) ? 32'd1 : 32'd0);
      check("err_hready", 32'(err_hready), (m_err_left == 2) ? 32'd0 : 32'd1);
      check("err_count",  32'(err_count), 32'(m_cnt));
   endtask

   // One bus cycle: drive at negedge, check combinational, clock, check registers.
   task automatic cycle(input logic [1:0] tr, input logic rdy, input logic [31:0] a,
                        input logic [31:0] d, input logic w);
      logic [2:0] s;
      logic       act;
      @(negedge Hclk);
      Htrans = tr; Hreadyin = rdy; Haddr = a; Hwdata = d; Hwrite = w;
      Prdata = $urandom;
      #1;
      s   = model_sel(a);
      act = rdy & tr[1];
      check("tempselx", 32'(tempselx), 32'(s));
      check("valid", 32'(valid), 32'(act && (s != 3'b000) && (m_err_left == 0)));
      check("hrdata", Hrdata, Prdata);
      @(posedge Hclk);
      m_a2 = m_a1; m_a1 = a; m_d2 = m_d1; m_d1 = d; m_w = w;
      if (m_err_left > 0) m_err_left--;
      else if (act && s == 3'b000) begin
         m_err_left = 2;
         if (m_cnt < 255) m_cnt++;
      end
      #1;
      check_regs();
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return BASE - 32'($urandom_range(0, 16));
         2:       return 32'(longint'(BASE) + 3 * RSIZE) - 32'($urandom_range(0, 16)) + 32'd8;
         default: return BASE + 32'($urandom_range(0, 32'h0FFF_FFFF));
      endcase
   endfunction

   initial begin
      Hresetn = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b10;
      Haddr = BASE; Hwdata = '0; Prdata = 32'h1234_5678;
      #2 Hresetn = 1'b0;
      #1;
      model_reset();
      check("rst_valid", 32'(valid), 32'd1);
      check("rst_sel",   32'(tempselx), 32'd1);
      check_regs();
      @(posedge Hclk); #1;
      check_regs();
      #2 Hresetn = 1'b1;

      // Decode of the three regions and the pipeline delays.
      cycle(2'b10, 1'b1, 32'h8000_0004, $urandom, 1'b1);
      cycle(2'b10, 1'b1, 32'h8400_0000, $urandom, 1'b1);
      cycle(2'b10, 1'b1, 32'h8BFF_FFFC, $urandom, 1'b1);
      cycle(2'b00, 1'b1, 32'h8BFF_FFFF, $urandom, 1'b0);
      cycle(2'b00, 1'b1, 32'h0000_0000, $urandom, 1'b0);

      // Transfer qualification.
      cycle(2'b00, 1'b1, BASE, $urandom, 1'b0);
      cycle(2'b01, 1'b1, BASE, $urandom, 1'b1);
      cycle(2'b10, 1'b0, BASE, $urandom, 1'b1);
      cycle(2'b11, 1'b0, 32'h8C00_0000, $urandom, 1'b1);

      // Unmapped active access, mapped NONSEQ during ERR1 is blocked.
      cycle(2'b10, 1'b1, 32'h8C00_0000, $urandom, 1'b1);
      cycle(2'b10, 1'b1, BASE, $urandom, 1'b1);
      cycle(2'b11, 1'b1, 32'h8C00_0000, $urandom, 1'b0);
      cycle(2'b00, 1'b1, BASE, $urandom, 1'b0);

      // Unmapped non-active access and window edges.
      cycle(2'b00, 1'b1, 32'h7FFF_FFFC, $urandom, 1'b0);
      cycle(2'b11, 1'b1, 32'h7FFF_FFFF, $urandom, 1'b0);
      cycle(2'b00, 1'b1, BASE, $urandom, 1'b0);
      cycle(2'b00, 1'b1, BASE, $urandom, 1'b0);
      cycle(2'b11, 1'b1, 32'h8BFF_FFFF, $urandom, 1'b0);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), rand_addr(),
               $urandom, 1'($urandom));

      // Counter saturation with back-to-back errors.
      for (int i = 0; i < 300; i++) begin
         cycle(2'b10, 1'b1, 32'h8C00_0000 + 32'(i), $urandom, 1'b1);
         cycle(2'b10, 1'b1, 32'hFFFF_FFF0, $urandom, 1'b0);
         cycle(2'b11, 1'b1, 32'h0000_0100, $urandom, 1'b0);
      end
      check("sat_count", 32'(err_count), 32'h0000_00FF);

      // Reset asserted while in ERR1.
      cycle(2'b10, 1'b1, 32'h9000_0000, $urandom, 1'b1);
      check("pre_rst_resp", 32'(Hresp), 32'd1);
      Hresetn = 1'b0;
      #1;
      model_reset();
      check("rst_err_resp",  32'(Hresp), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check_regs();
      #2 Hresetn = 1'b1;
      cycle(2'b10, 1'b1, BASE, $urandom, 1'b1);
      cycle(2'b10, 1'b1, 32'h8C00_0000, $urandom, 1'b1);
      cycle(2'b00, 1'b1, BASE, $urandom, 1'b0);
      cycle(2'b00, 1'b1, BASE, $urandom, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
